// File: rtl/eh2_exu_alu_arb.sv
// Round-robin issue arbiter sharing one EXU ALU pipe between hardware threads.
// Optional conflict counter enabled by defining RV_ALU_ARB_PERF_EN.
module eh2_exu_alu_arb #(
  parameter int NUM_THREADS = 2,
  parameter int PKT_W       = 64
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic [NUM_THREADS-1:0]       req_valid,
  input  logic [NUM_THREADS*PKT_W-1:0] req_pkt,
  output logic [NUM_THREADS-1:0]       req_ready,
  input  logic [NUM_THREADS-1:0]       flush,
  input  logic [NUM_THREADS-1:0]       flush_upper,
  input  logic                         alu_stall,
  output logic                         alu_valid,
  output logic                         alu_enable,
  output logic                         alu_tid,
  output logic [PKT_W-1:0]             alu_pkt,
  output logic [15:0]                  perf_conflict_cnt
);

  // Internal datapath is always two threads wide; the unused thread is tied off.
  logic [1:0]           req_valid_s;
  logic [1:0]           flush_s;
  logic [1:0]           flush_upper_s;
  logic [2*PKT_W-1:0]   req_pkt_s;

  generate
    if (NUM_THREADS == 2) begin : g_two
      assign req_valid_s   = req_valid;
      assign flush_s       = flush;
      assign flush_upper_s = flush_upper;
      assign req_pkt_s     = req_pkt;
    end else begin : g_one
      assign req_valid_s   = {1'b0, req_valid};
      assign flush_s       = {1'b0, flush};
      assign flush_upper_s = {1'b0, flush_upper};
      assign req_pkt_s     = {{PKT_W{1'b0}}, req_pkt};
    end
  endgenerate

  logic [1:0]            buf_v_q, buf_v_d;
  logic [1:0][PKT_W-1:0] buf_pkt_q, buf_pkt_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic                  iss_v_q, iss_v_d;
  logic                  iss_tid_q, iss_tid_d;
  logic [PKT_W-1:0]      iss_pkt_q, iss_pkt_d;

  logic [1:0] kill_s, cand_s, grant_s, ready_s, acc_s;
  logic       load_s, gnt_any_s, gnt_tid_s;

  // Kill, load strobe, round-robin grant and buffer readiness.
  always_comb begin
    kill_s    = flush_s | flush_upper_s;
    cand_s    = buf_v_q & ~kill_s;
    load_s    = ~alu_stall | ~iss_v_q | kill_s[iss_tid_q];
    gnt_any_s = 1'b0;
    gnt_tid_s = 1'b0;
    case (cand_s)
      2'b11: begin
        gnt_any_s = 1'b1;
        gnt_tid_s = rr_ptr_q;
      end
      2'b01: begin
        gnt_any_s = 1'b1;
        gnt_tid_s = 1'b0;
      end
      2'b10: begin
        gnt_any_s = 1'b1;
        gnt_tid_s = 1'b1;
      end
      default: begin
        gnt_any_s = 1'b0;
        gnt_tid_s = 1'b0;
      end
    endcase
    if (gnt_any_s) begin
      grant_s = gnt_tid_s ? 2'b10 : 2'b01;
    end else begin
      grant_s = 2'b00;
    end
    ready_s = ~buf_v_q | (grant_s & {2{load_s}});
    acc_s   = req_valid_s & ready_s & ~kill_s;
  end

  // Next state for holding buffers and issue stage; kill wins over accept and stall.
  always_comb begin
    buf_v_d   = buf_v_q;
    buf_pkt_d = buf_pkt_q;
    for (int i = 0; i < 2; i++) begin
      if (kill_s[i]) begin
        buf_v_d[i] = 1'b0;
      end else if (acc_s[i]) begin
        buf_v_d[i]   = 1'b1;
        buf_pkt_d[i] = req_pkt_s[i*PKT_W +: PKT_W];
      end else if (grant_s[i] && load_s) begin
        buf_v_d[i] = 1'b0;
      end else begin
        buf_v_d[i] = buf_v_q[i];
      end
    end
    iss_v_d   = iss_v_q;
    iss_tid_d = iss_tid_q;
    iss_pkt_d = iss_pkt_q;
    rr_ptr_d  = rr_ptr_q;
    if (load_s) begin
      if (gnt_any_s) begin
        iss_v_d   = 1'b1;
        iss_tid_d = gnt_tid_s;
        iss_pkt_d = buf_pkt_q[gnt_tid_s];
        rr_ptr_d  = (NUM_THREADS == 2) ? ~gnt_tid_s : 1'b0;
      end else begin
        iss_v_d = 1'b0;
      end
    end else begin
      iss_v_d = iss_v_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      buf_v_q   <= 2'b00;
      buf_pkt_q <= '0;
      rr_ptr_q  <= 1'b0;
      iss_v_q   <= 1'b0;
      iss_tid_q <= 1'b0;
      iss_pkt_q <= {PKT_W{1'b0}};
    end else begin
      buf_v_q   <= buf_v_d;
      buf_pkt_q <= buf_pkt_d;
      rr_ptr_q  <= rr_ptr_d;
      iss_v_q   <= iss_v_d;
      iss_tid_q <= iss_tid_d;
      iss_pkt_q <= iss_pkt_d;
    end
  end

  assign req_ready  = ready_s[NUM_THREADS-1:0];
  assign alu_valid  = iss_v_q;
  assign alu_tid    = iss_tid_q;
  assign alu_pkt    = iss_pkt_q;
  assign alu_enable = load_s & gnt_any_s;

`ifdef RV_ALU_ARB_PERF_EN
  logic [15:0] perf_cnt_q, perf_cnt_d;

  // Saturating count of cycles where both threads compete.
  always_comb begin
    if (cand_s[0] && cand_s[1] && (perf_cnt_q != 16'hFFFF)) begin
      perf_cnt_d = perf_cnt_q + 16'd1;
    end else begin
      perf_cnt_d = perf_cnt_q;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      perf_cnt_q <= 16'h0000;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_conflict_cnt = perf_cnt_q;
`else
  assign perf_conflict_cnt = 16'h0000;
`endif

endmodule
